// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: opcodes, ALU operation codes and sequencer states.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JC  = 4'hA;
  localparam logic [3:0] OP_OUT = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5,
    ALU_NOT  = 3'd6
  } alu_op_t;

  typedef enum logic [1:0] {
    JC_ALWAYS = 2'd0,
    JC_ZERO   = 2'd1,
    JC_CARRY  = 2'd2
  } jmp_cond_t;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    STEP_WAIT = 3'd3,
    HALT      = 3'd4
  } state_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decode into ALU operation, write strobes and jump/halt qualifiers.
module opcode_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output alu_op_t    alu_op,
  output logic       acc_load,
  output logic       out_load,
  output logic       is_jmp,
  output jmp_cond_t  jmp_cond,
  output logic       is_hlt
);

  always_comb begin
    alu_op   = ALU_PASS;
    acc_load = 1'b0;
    out_load = 1'b0;
    is_jmp   = 1'b0;
    jmp_cond = JC_ALWAYS;
    is_hlt   = 1'b0;
    case (opcode)
      OP_LDI: begin alu_op = ALU_PASS; acc_load = 1'b1; end
      OP_ADD: begin alu_op = ALU_ADD;  acc_load = 1'b1; end
      OP_SUB: begin alu_op = ALU_SUB;  acc_load = 1'b1; end
      OP_AND: begin alu_op = ALU_AND;  acc_load = 1'b1; end
      OP_OR:  begin alu_op = ALU_OR;   acc_load = 1'b1; end
      OP_XOR: begin alu_op = ALU_XOR;  acc_load = 1'b1; end
      OP_NOT: begin alu_op = ALU_NOT;  acc_load = 1'b1; end
      OP_JMP: begin is_jmp = 1'b1; jmp_cond = JC_ALWAYS; end
      OP_JZ:  begin is_jmp = 1'b1; jmp_cond = JC_ZERO;   end
      OP_JC:  begin is_jmp = 1'b1; jmp_cond = JC_CARRY;  end
      OP_OUT: out_load = 1'b1;
      OP_HLT: is_hlt = 1'b1;
      // NOP and the unassigned codes 0xC-0xE leave everything idle
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for the 4-bit CPU.
// Optional SEQ_SINGLE_STEP_EN adds a Step input that gates each new fetch after EXECUTE.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int OP_W   = 4
) (
  input  logic              Clk,
  input  logic              Rst,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              Step,
`endif
  input  logic [OP_W-1:0]   OpCode,
  input  logic [OP_W-1:0]   Operand,
  input  logic              Zero,
  input  logic              Carry,
  input  logic              Mem_Ready,
  output logic [ADDR_W-1:0] PC,
  output logic              Mem_Req,
  output logic              IR_Load,
  output logic [2:0]        ALU_Op,
  output logic              Acc_Load,
  output logic              Out_Load,
  output logic              Halted
);

  state_t              state_reg;
  logic [ADDR_W-1:0]   pc_reg;

  alu_op_t             dec_alu_op;
  logic                dec_acc_load;
  logic                dec_out_load;
  logic                dec_is_jmp;
  jmp_cond_t           dec_jmp_cond;
  logic                dec_is_hlt;
  logic                take_jump;
  logic                in_exec;

  opcode_decoder u_dec (
    .opcode   (OpCode[3:0]),
    .alu_op   (dec_alu_op),
    .acc_load (dec_acc_load),
    .out_load (dec_out_load),
    .is_jmp   (dec_is_jmp),
    .jmp_cond (dec_jmp_cond),
    .is_hlt   (dec_is_hlt)
  );

  assign take_jump = dec_is_jmp &&
                     ((dec_jmp_cond == JC_ALWAYS) ||
                      ((dec_jmp_cond == JC_ZERO)  && Zero) ||
                      ((dec_jmp_cond == JC_CARRY) && Carry));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg <= FETCH;
      pc_reg    <= '0;
    end else begin
      case (state_reg)
        FETCH:
          if (Mem_Ready) state_reg <= DECODE;
        DECODE: begin
          pc_reg    <= pc_reg + ADDR_W'(1);
          state_reg <= EXECUTE;
        end
        EXECUTE: begin
          // A taken jump replaces the increment already applied in DECODE
          if (take_jump) pc_reg <= ADDR_W'(Operand);
          if (dec_is_hlt)
            state_reg <= HALT;
          else
`ifdef SEQ_SINGLE_STEP_EN
            state_reg <= STEP_WAIT;
`else
            state_reg <= FETCH;
`endif
        end
        STEP_WAIT: begin
`ifdef SEQ_SINGLE_STEP_EN
          if (Step) state_reg <= FETCH;
`else
          state_reg <= FETCH;
`endif
        end
        HALT:
          state_reg <= HALT;
        default:
          state_reg <= FETCH;
      endcase
    end
  end

  assign in_exec  = (state_reg == EXECUTE);
  // Request drops as soon as Rst is seen so a pending fetch is abandoned
  assign Mem_Req  = (state_reg == FETCH) && !Rst;
  assign IR_Load  = Mem_Req && Mem_Ready;
  assign ALU_Op   = in_exec ? dec_alu_op : ALU_PASS;
  assign Acc_Load = in_exec && dec_acc_load;
  assign Out_Load = in_exec && dec_out_load;
  assign Halted   = (state_reg == HALT);
  assign PC       = pc_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer (both with and without SEQ_SINGLE_STEP_EN).
module tb_control_sequencer;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Step;
  logic [3:0] OpCode;
  logic [3:0] Operand;
  logic       Zero;
  logic       Carry;
  logic       Mem_Ready;
  logic [3:0] PC;
  logic       Mem_Req;
  logic       IR_Load;
  logic [2:0] ALU_Op;
  logic       Acc_Load;
  logic       Out_Load;
  logic       Halted;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  control_sequencer #(.ADDR_W(4), .OP_W(4)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
`ifdef SEQ_SINGLE_STEP_EN
    .Step      (Step),
`endif
    .OpCode    (OpCode),
    .Operand   (Operand),
    .Zero      (Zero),
    .Carry     (Carry),
    .Mem_Ready (Mem_Ready),
    .PC        (PC),
    .Mem_Req   (Mem_Req),
    .IR_Load   (IR_Load),
    .ALU_Op    (ALU_Op),
    .Acc_Load  (Acc_Load),
    .Out_Load  (Out_Load),
    .Halted    (Halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge
  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic step_release();
`ifdef SEQ_SINGLE_STEP_EN
    Step = 1'b1;
    tick();
    Step = 1'b0;
`endif
  endtask

  // Starts in a FETCH cycle with memory ready; ends in the following state after EXECUTE
  task automatic run_instr(input string tag, input logic [3:0] op, input logic [3:0] opr,
                           input logic z, input logic c, input logic [2:0] exp_alu,
                           input logic exp_acc, input logic exp_out);
    Mem_Ready = 1'b1;
    OpCode    = op;
    Operand   = opr;
    Zero      = z;
    Carry     = c;
    #1;
    $display("instr %s op=%h operand=%h pc=%0d", tag, op, opr, PC);
    check_eq({tag, " fetch IR_Load"}, IR_Load, 1);
    check_eq({tag, " fetch Mem_Req"}, Mem_Req, 1);
    tick();
    #1;
    check_eq({tag, " decode IR_Load"}, IR_Load, 0);
    check_eq({tag, " decode Acc_Load"}, Acc_Load, 0);
    tick();
    #1;
    check_eq({tag, " exec ALU_Op"}, ALU_Op, exp_alu);
    check_eq({tag, " exec Acc_Load"}, Acc_Load, exp_acc);
    check_eq({tag, " exec Out_Load"}, Out_Load, exp_out);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Rst = 1'b1; Step = 1'b0; OpCode = '0; Operand = '0;
    Zero = 1'b0; Carry = 1'b0; Mem_Ready = 1'b0;
    tick();
    tick();
    #1;
    check_eq("reset Mem_Req", Mem_Req, 0);
    check_eq("reset PC", PC, 0);
    check_eq("reset Halted", Halted, 0);
    check_eq("reset ALU_Op", ALU_Op, 0);
    check_eq("reset Acc_Load", Acc_Load, 0);
    Rst = 1'b0;
    #1;
    check_eq("post-reset Mem_Req", Mem_Req, 1);

    run_instr("LDI5", 4'h1, 4'h5, 0, 0, 3'd0, 1, 0);
    step_release();
    #1;
    check_eq("LDI cycle4 PC", PC, 1);
    check_eq("LDI cycle4 Mem_Req", Mem_Req, 1);

    Mem_Ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("wait Mem_Req", Mem_Req, 1);
      check_eq("wait IR_Load", IR_Load, 0);
      check_eq("wait PC", PC, 1);
      tick();
    end
    run_instr("ADD3", 4'h2, 4'h3, 0, 0, 3'd1, 1, 0);
    step_release();
    #1; check_eq("ADD PC", PC, 2);

    run_instr("JZ9 z1", 4'h9, 4'h9, 1, 0, 3'd0, 0, 0);
    step_release();
    #1; check_eq("JZ taken PC", PC, 9);
    run_instr("JZ9 z0", 4'h9, 4'h9, 0, 0, 3'd0, 0, 0);
    step_release();
    #1; check_eq("JZ not taken PC", PC, 10);
    run_instr("JC3 c1", 4'hA, 4'h3, 0, 1, 3'd0, 0, 0);
    step_release();
    #1; check_eq("JC taken PC", PC, 3);
    run_instr("JC7 c0", 4'hA, 4'h7, 1, 0, 3'd0, 0, 0);
    step_release();
    #1; check_eq("JC not taken PC", PC, 4);
    run_instr("OUT", 4'hB, 4'h0, 0, 0, 3'd0, 0, 1);
    step_release();
    #1; check_eq("OUT PC", PC, 5);
    run_instr("NOT", 4'h7, 4'h0, 0, 0, 3'd6, 1, 0);
    step_release();
    #1; check_eq("NOT PC", PC, 6);
    run_instr("SUB", 4'h3, 4'h1, 0, 0, 3'd2, 1, 0);
    step_release();
    #1; check_eq("SUB PC", PC, 7);
    run_instr("JMP15", 4'h8, 4'hF, 0, 0, 3'd0, 0, 0);
    step_release();
    #1; check_eq("JMP PC", PC, 15);
    run_instr("NOP@15", 4'h0, 4'h0, 0, 0, 3'd0, 0, 0);
    step_release();
    #1; check_eq("wrap PC", PC, 0);
    run_instr("OP_D", 4'hD, 4'h9, 1, 1, 3'd0, 0, 0);
    step_release();
    #1; check_eq("opD PC", PC, 1);
    check_eq("opD Halted", Halted, 0);
    run_instr("JMP self", 4'h8, 4'h1, 0, 0, 3'd0, 0, 0);
    step_release();
    #1; check_eq("JMP self PC", PC, 1);

    Mem_Ready = 1'b0;
    tick();
    Rst = 1'b1;
    #1;
    check_eq("rst in wait Mem_Req", Mem_Req, 0);
    tick();
    Rst = 1'b0;
    #1;
    check_eq("rst in wait PC", PC, 0);
    check_eq("rst in wait refetch", Mem_Req, 1);

`ifdef SEQ_SINGLE_STEP_EN
    Mem_Ready = 1'b1;
    run_instr("ADD2 step", 4'h2, 4'h2, 0, 0, 3'd1, 1, 0);
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("step hold Mem_Req", Mem_Req, 0);
      check_eq("step hold Acc_Load", Acc_Load, 0);
      tick();
    end
    Step = 1'b1;
    tick();
    Step = 1'b0;
    #1;
    check_eq("step release Mem_Req", Mem_Req, 1);
`else
    run_instr("ADD2", 4'h2, 4'h2, 0, 0, 3'd1, 1, 0);
    #1;
    check_eq("ADD2 next fetch", Mem_Req, 1);
`endif
    check_eq("ADD2 PC", PC, 1);

    run_instr("HLT", 4'hF, 4'h0, 0, 0, 3'd0, 0, 0);
    #1;
    check_eq("HLT Halted", Halted, 1);
    Mem_Ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      check_eq("halt Mem_Req", Mem_Req, 0);
      check_eq("halt PC", PC, 2);
      check_eq("halt Halted", Halted, 1);
      tick();
    end
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    #1;
    check_eq("unhalt PC", PC, 0);
    check_eq("unhalt Halted", Halted, 0);
    check_eq("unhalt Mem_Req", Mem_Req, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
